// File: rtl/conv_layer_sequencer.sv
// Layer-level control FSM for the 3x3 convolution datapath: walks output channels,
// input channels and image rows, issuing kernel-load, row-stream and commit handshakes.
module conv_layer_sequencer #(
    parameter int IMG_LOG2_MAX = 7,
    parameter int CH_W         = 9,
    parameter int ROW_W        = IMG_LOG2_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       img_log2,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [CH_W-1:0]  out_ch,
    output logic             ker_load_req,
    input  logic             ker_load_done,
    input  logic             dp_idle,
    output logic             row_start,
    output logic [1:0]       row_type,
    input  logic             row_done,
    output logic             acc_clear,
    output logic             oc_commit,
    input  logic             commit_done,
    output logic [ROW_W-1:0] cur_row,
    output logic [CH_W-1:0]  cur_ic,
    output logic [CH_W-1:0]  cur_oc,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_WAIT_KER,
        S_WAIT_IDLE,
        S_ROW,
        S_ROW_WAIT,
        S_NEXT_IC,
        S_WAIT_IDLE_C,
        S_COMMIT,
        S_WAIT_COMMIT,
        S_DONE
    } state_t;

    localparam logic [CH_W-1:0] CH_MAX   = {1'b1, {(CH_W-1){1'b0}}};
    localparam logic [31:0]     LOG2_MAX = 32'(IMG_LOG2_MAX);

    state_t            state;
    state_t            state_n;
    logic [2:0]        lat_log2;
    logic [CH_W-1:0]   lat_in;
    logic [CH_W-1:0]   lat_out;
    logic [ROW_W-1:0]  row_n;
    logic [CH_W-1:0]   ic_n;
    logic [CH_W-1:0]   oc_n;
    logic              err_n;
    logic              latch_cfg;
    logic              cfg_ok;
    logic [ROW_W-1:0]  row_last;
    logic [CH_W-1:0]   ic_last;
    logic [CH_W-1:0]   oc_last;

    // N-1 as a mask of img_log2 ones; stays correct when N == 2^ROW_W.
    assign row_last = ~({ROW_W{1'b1}} << lat_log2);
    assign ic_last  = lat_in  - CH_W'(1);
    assign oc_last  = lat_out - CH_W'(1);

    assign cfg_ok = (lat_log2 >= 3'd2) && ({29'd0, lat_log2} <= LOG2_MAX)
                 && (lat_in  != '0) && (lat_in  <= CH_MAX)
                 && (lat_out != '0) && (lat_out <= CH_MAX);

    always_comb begin
        state_n   = state;
        row_n     = cur_row;
        ic_n      = cur_ic;
        oc_n      = cur_oc;
        err_n     = cfg_err;
        latch_cfg = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    err_n     = 1'b0;
                    state_n   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!cfg_ok) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    row_n   = '0;
                    ic_n    = '0;
                    oc_n    = '0;
                    state_n = S_LOAD;
                end
            end
            S_LOAD:      state_n = S_WAIT_KER;
            S_WAIT_KER:  if (ker_load_done) state_n = S_WAIT_IDLE;
            S_WAIT_IDLE: if (dp_idle) state_n = S_ROW;
            S_ROW:       state_n = S_ROW_WAIT;
            S_ROW_WAIT: begin
                if (row_done) begin
                    if (cur_row < row_last) begin
                        row_n   = cur_row + ROW_W'(1);
                        state_n = S_WAIT_IDLE;
                    end else begin
                        row_n   = '0;
                        state_n = S_NEXT_IC;
                    end
                end
            end
            S_NEXT_IC: begin
                if (cur_ic < ic_last) begin
                    ic_n    = cur_ic + CH_W'(1);
                    state_n = S_LOAD;
                end else begin
                    ic_n    = '0;
                    state_n = S_WAIT_IDLE_C;
                end
            end
            S_WAIT_IDLE_C: if (dp_idle) state_n = S_COMMIT;
            S_COMMIT:      state_n = S_WAIT_COMMIT;
            S_WAIT_COMMIT: begin
                if (commit_done) begin
                    if (cur_oc < oc_last) begin
                        oc_n    = cur_oc + CH_W'(1);
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Abort outranks every handshake; in IDLE a start always wins.
        if (abort && (state != S_IDLE)) begin
            state_n   = S_IDLE;
            row_n     = '0;
            ic_n      = '0;
            oc_n      = '0;
            err_n     = cfg_err;
            latch_cfg = 1'b0;
        end
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lat_log2     <= '0;
            lat_in       <= '0;
            lat_out      <= '0;
            cur_row      <= '0;
            cur_ic       <= '0;
            cur_oc       <= '0;
            cfg_err      <= 1'b0;
            ker_load_req <= 1'b0;
            row_start    <= 1'b0;
            row_type     <= 2'd0;
            acc_clear    <= 1'b0;
            oc_commit    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state   <= state_n;
            cur_row <= row_n;
            cur_ic  <= ic_n;
            cur_oc  <= oc_n;
            cfg_err <= err_n;
            if (latch_cfg) begin
                lat_log2 <= img_log2;
                lat_in   <= in_ch;
                lat_out  <= out_ch;
            end
            ker_load_req <= (state_n == S_LOAD);
            row_start    <= (state_n == S_ROW);
            oc_commit    <= (state_n == S_COMMIT);
            done         <= (state_n == S_DONE);
            busy         <= (state_n != S_IDLE);
            acc_clear    <= (state_n != S_IDLE) && (ic_n == '0);
            if (row_n == '0) begin
                row_type <= 2'd0;
            end else if (row_n == row_last) begin
                row_type <= 2'd2;
            end else begin
                row_type <= 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: auto-responding handshakes plus an event
// scoreboard built from the layer configuration and checked as the DUT emits pulses.
module tb_conv_layer_sequencer;

    localparam int IMG_LOG2_MAX = 7;
    localparam int CH_W         = 9;
    localparam int ROW_W        = IMG_LOG2_MAX;
    localparam int K_LOAD = 0, K_ROW = 1, K_COMMIT = 2, K_DONE = 3;

    typedef struct {
        int kind;
        int oc;
        int ic;
        int row;
        int rtype;
        int acc;
        int err;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [2:0]       img_log2 = '0;
    logic [CH_W-1:0]  in_ch = '0;
    logic [CH_W-1:0]  out_ch = '0;
    logic             ker_load_req;
    logic             ker_load_done = 1'b0;
    logic             dp_idle = 1'b1;
    logic             row_start;
    logic [1:0]       row_type;
    logic             row_done = 1'b0;
    logic             acc_clear;
    logic             oc_commit;
    logic             commit_done = 1'b0;
    logic [ROW_W-1:0] cur_row;
    logic [CH_W-1:0]  cur_ic;
    logic [CH_W-1:0]  cur_oc;
    logic             busy;
    logic             done;
    logic             cfg_err;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  ker_dly = 1, row_dly = 1, com_dly = 1;
    int  rows_seen = 0;
    int  abort_row = 0;
    int  n_ker = 0, n_row = 0, n_com = 0, n_done = 0, n_acc = 0;

    always #5 clk = ~clk;

    conv_layer_sequencer #(
        .IMG_LOG2_MAX(IMG_LOG2_MAX),
        .CH_W        (CH_W),
        .ROW_W       (ROW_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .img_log2     (img_log2),
        .in_ch        (in_ch),
        .out_ch       (out_ch),
        .ker_load_req (ker_load_req),
        .ker_load_done(ker_load_done),
        .dp_idle      (dp_idle),
        .row_start    (row_start),
        .row_type     (row_type),
        .row_done     (row_done),
        .acc_clear    (acc_clear),
        .oc_commit    (oc_commit),
        .commit_done  (commit_done),
        .cur_row      (cur_row),
        .cur_ic       (cur_ic),
        .cur_oc       (cur_oc),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int oc, input int ic, input int row,
                        input int rtype, input int acc, input int err);
        ev_t e;
        e = '{kind, oc, ic, row, rtype, acc, err};
        exp_q.push_back(e);
    endtask

    // Expected event stream of a whole layer, truncated after 'limit' entries.
    task automatic build_layer(input int l2, input int ic, input int oc, input int limit);
        int n;
        bit legal;
        n = 1 << l2;
        legal = (l2 >= 2) && (l2 <= IMG_LOG2_MAX) && (ic >= 1) && (ic <= (1 << (CH_W-1)))
             && (oc >= 1) && (oc <= (1 << (CH_W-1)));
        if (!legal) begin
            push(K_DONE, 0, 0, 0, 0, 0, 1);
            return;
        end
        for (int o = 0; o < oc; o++) begin
            for (int i = 0; i < ic; i++) begin
                if (exp_q.size() >= limit) return;
                push(K_LOAD, o, i, 0, 0, 0, 0);
                for (int r = 0; r < n; r++) begin
                    push(K_ROW, o, i, r, (r == 0) ? 0 : ((r == n-1) ? 2 : 1), (i == 0) ? 1 : 0, 0);
                end
            end
            push(K_COMMIT, o, 0, 0, 0, 0, 0);
        end
        push(K_DONE, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic match(input int kind);
        ev_t e;
        chk("sb_expected_event", (exp_q.size() != 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("ev_kind", kind, e.kind);
        case (kind)
            K_LOAD: begin
                chk("load_oc", cur_oc, e.oc);
                chk("load_ic", cur_ic, e.ic);
            end
            K_ROW: begin
                chk("row_oc", cur_oc, e.oc);
                chk("row_ic", cur_ic, e.ic);
                chk("row_idx", cur_row, e.row);
                chk("row_type", row_type, e.rtype);
                chk("row_acc_clear", acc_clear, e.acc);
            end
            K_COMMIT: chk("commit_oc", cur_oc, e.oc);
            default:  chk("done_cfg_err", cfg_err, e.err);
        endcase
    endtask

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (ker_load_req) begin n_ker++; match(K_LOAD); end
            if (row_start) begin n_row++; if (acc_clear) n_acc++; match(K_ROW); end
            if (oc_commit) begin n_com++; match(K_COMMIT); end
            if (done) begin n_done++; match(K_DONE); end
        end
    end

    // Handshake responders.
    initial forever begin
        @(negedge clk);
        if (ker_load_req && !reset) begin
            repeat (ker_dly) @(negedge clk);
            ker_load_done = 1'b1;
            @(negedge clk);
            ker_load_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (row_start && !reset) begin
            rows_seen++;
            repeat (row_dly) @(negedge clk);
            row_done = 1'b1;
            if ((abort_row != 0) && (rows_seen == abort_row)) abort = 1'b1;
            @(negedge clk);
            row_done = 1'b0;
            abort    = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (oc_commit && !reset) begin
            repeat (com_dly) @(negedge clk);
            commit_done = 1'b1;
            @(negedge clk);
            commit_done = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input int l2, input int ic, input int oc);
        @(negedge clk);
        img_log2 = 3'(l2);
        in_ch    = CH_W'(ic);
        out_ch   = CH_W'(oc);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        img_log2 = 3'd1;
        in_ch    = '0;
        out_ch   = '0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int c;
        for (c = 0; c < lim; c++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(tag, (c < lim), 1);
        #1;
    endtask

    initial begin
        int b_ker, b_row, b_com, b_done, b_acc, seen, c;
        int l2s[4] = '{2, 1, 2, 2};
        int ics[4] = '{0, 1, 257, 1};
        int ocs[4] = '{1, 1, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {ker_load_req, row_start, row_type, acc_clear, oc_commit, busy, done, cfg_err}, 0);
        chk("rst_cnt", {cur_row, cur_ic, cur_oc}, 0);
        reset = 1'b0;

        // Smallest legal layer.
        b_ker = n_ker; b_row = n_row; b_com = n_com;
        build_layer(2, 1, 1, 1 << 30);
        do_start(2, 1, 1);
        chk("t1_busy", busy, 1);
        chk("t1_req_not_yet", ker_load_req, 0);
        @(negedge clk);
        chk("t1_latency_req", ker_load_req, 1);
        wait_done("t1_done_seen", 200);
        chk("t1_loads", n_ker - b_ker, 1);
        chk("t1_rows", n_row - b_row, 4);
        chk("t1_commits", n_com - b_com, 1);
        chk("t1_cfg_err", cfg_err, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Multi-channel layer with slower handshakes.
        ker_dly = 2; row_dly = 3; com_dly = 2;
        b_ker = n_ker; b_row = n_row; b_com = n_com; b_acc = n_acc;
        build_layer(3, 3, 2, 1 << 30);
        do_start(3, 3, 2);
        wait_done("t2_done_seen", 3000);
        chk("t2_loads", n_ker - b_ker, 6);
        chk("t2_rows", n_row - b_row, 48);
        chk("t2_commits", n_com - b_com, 2);
        chk("t2_acc_rows", n_acc - b_acc, 16);
        chk("t2_last_oc", cur_oc, 1);
        chk("t2_sb_empty", exp_q.size(), 0);
        ker_dly = 1; row_dly = 1; com_dly = 1;

        // Illegal configurations end two cycles after start with cfg_err.
        for (int k = 0; k < 4; k++) begin
            b_ker = n_ker;
            build_layer(l2s[k], ics[k], ocs[k], 1 << 30);
            do_start(l2s[k], ics[k], ocs[k]);
            @(negedge clk);
            chk("err_done", done, 1);
            chk("err_flag", cfg_err, 1);
            @(negedge clk);
            chk("err_idle", busy, 0);
            chk("err_flag_held", cfg_err, 1);
            chk("err_no_load", n_ker - b_ker, 0);
        end
        build_layer(2, 1, 1, 1 << 30);
        do_start(2, 1, 1);
        chk("err_cleared", cfg_err, 0);
        wait_done("err_recover_done", 200);
        chk("err_sb_empty", exp_q.size(), 0);

        // Abort coincident with row_done.
        build_layer(2, 2, 1, 1 << 30);
        abort_row = rows_seen + 7;
        b_done = n_done;
        do_start(2, 2, 1);
        for (c = 0; c < 500; c++) begin
            @(posedge clk);
            if (abort) break;
        end
        chk("abort_seen", (c < 500), 1);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", {cur_row, cur_ic, cur_oc}, 0);
        chk("abort_cfg_err", cfg_err, 0);
        abort_row = 0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_done", n_done - b_done, 0);
        b_row = n_row;
        build_layer(2, 2, 1, 1 << 30);
        do_start(2, 2, 1);
        wait_done("abort_rerun_done", 300);
        chk("abort_rerun_rows", n_row - b_row, 8);
        chk("abort_sb_empty", exp_q.size(), 0);

        // dp_idle held low; starts while busy are ignored.
        dp_idle = 1'b0;
        b_row = n_row; b_ker = n_ker;
        build_layer(2, 1, 1, 1 << 30);
        do_start(2, 1, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 6 || i == 12) begin
                start = 1'b1; img_log2 = 3'd3; in_ch = CH_W'(2);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("dp_hold_rows", n_row - b_row, 0);
        chk("dp_hold_loads", n_ker - b_ker, 1);
        chk("dp_hold_busy", busy, 1);
        dp_idle = 1'b1;
        @(negedge clk);
        chk("dp_release_row", row_start, 1);
        wait_done("dp_done_seen", 200);
        chk("dp_rows", n_row - b_row, 4);
        chk("dp_sb_empty", exp_q.size(), 0);

        // Full channel width: 256 output channels without wrap.
        b_row = n_row; b_com = n_com; b_done = n_done;
        build_layer(2, 1, 256, 1 << 30);
        do_start(2, 1, 256);
        wait_done("fw_done_seen", 20000);
        chk("fw_last_oc", cur_oc, 255);
        chk("fw_rows", n_row - b_row, 1024);
        chk("fw_commits", n_com - b_com, 256);
        repeat (4) @(negedge clk);
        #1;
        chk("fw_done_once", n_done - b_done, 1);
        chk("fw_sb_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a large layer.
        build_layer(7, 256, 256, 10);
        do_start(7, 256, 256);
        seen = 0;
        for (c = 0; c < 400 && seen < 3; c++) begin
            @(negedge clk);
            if (row_start) seen++;
        end
        chk("rst_rows_before", seen, 3);
        @(posedge clk);
        #2;
        chk("rst_pre_row", cur_row, 2);
        chk("rst_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", {ker_load_req, row_start, row_type, acc_clear, oc_commit, busy, done, cfg_err}, 0);
        chk("rst_mid_cnt", {cur_row, cur_ic, cur_oc}, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_after_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Parametrised successor to the single-output-channel conv control unit.
- Sequences a full 3x3 convolution layer: all output channels and, for each, all input channels, streaming every image row through the line buffer/PE datapath as first/mid/last row.
- Row, input-channel and output-channel counters are internal, so no external row counter or last-channel register is needed.
- Adds a runtime-sized configuration (with an error check), abort, partial-sum accumulate/clear control and a per-output-channel commit handshake.

Parameters:
- IMG_LOG2_MAX, 7, largest supported image side is 2^IMG_LOG2_MAX (128).
- CH_W, 9, width of the channel-count inputs and channel counters (max 256 channels).
- ROW_W, IMG_LOG2_MAX, width of the row counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a layer; ignored while busy.
- abort  in  1  synchronous cancel of the current layer.
- img_log2  in  3  image side = 2^img_log2; legal range 2..IMG_LOG2_MAX.
- in_ch  in  CH_W  input-channel count; legal range 1..2^(CH_W-1).
- out_ch  in  CH_W  output-channel count; legal range 1..2^(CH_W-1).
- ker_load_req  out  1  one-cycle pulse: load the kernel for (cur_oc, cur_ic) into the PE registers.
- ker_load_done  in  1  pulse: kernel load is complete.
- dp_idle  in  1  line buffer and PE-with-buffers are both idle.
- row_start  out  1  one-cycle pulse: stream one row.
- row_type  out  2  0 = first, 1 = mid, 2 = last; held valid from row_start until row_done.
- row_done  in  1  pulse: the current row has finished streaming.
- acc_clear  out  1  level, high while cur_ic == 0; PE overwrites partial sums instead of accumulating.
- oc_commit  out  1  one-cycle pulse: write back the finished output channel.
- commit_done  in  1  pulse: write-back is complete.
- cur_row  out  ROW_W  current row index.
- cur_ic  out  CH_W  current input-channel index.
- cur_oc  out  CH_W  current output-channel index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a layer (normal or error).
- cfg_err  out  1  high with done when the latched configuration is illegal; cleared on the next start.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Configuration handling:
  - img_log2, in_ch and out_ch are latched on the cycle start is accepted.
  - Changes to these inputs during a layer have no effect.
- State machine (Moore outputs; one cycle per state unless a wait is stated):
  - IDLE: on start, latch config, clear cfg_err, go to CHECK.
  - CHECK: if the config is illegal, set cfg_err and go to DONE; otherwise clear all counters and go to LOAD.
  - LOAD: assert ker_load_req, go to WAIT_KER.
  - WAIT_KER: wait for ker_load_done, then go to WAIT_IDLE.
  - WAIT_IDLE: wait for dp_idle, then go to ROW.
  - ROW: assert row_start, go to ROW_WAIT.
  - ROW_WAIT: wait for row_done.
    - If cur_row < N-1: increment cur_row, go to WAIT_IDLE.
    - Otherwise: set cur_row = 0, go to NEXT_IC.
  - NEXT_IC:
    - If cur_ic < in_ch-1: increment cur_ic, go to LOAD.
    - Otherwise: set cur_ic = 0, go to WAIT_IDLE_C.
  - WAIT_IDLE_C: wait for dp_idle, then go to COMMIT.
  - COMMIT: assert oc_commit, go to WAIT_COMMIT.
  - WAIT_COMMIT: wait for commit_done.
    - If cur_oc < out_ch-1: increment cur_oc, go to LOAD.
    - Otherwise: go to DONE.
  - DONE: assert done for one cycle, go to IDLE.
- row_type, with N = 2^img_log2:
  - cur_row == 0 → first.
  - cur_row == N-1 → last.
  - All other rows → mid.
  - N >= 4 always, so every layer has at least one mid row.
- Latency: start → ker_load_req 2 cycles later (CHECK, then LOAD).
- Simultaneous events and overrides:
  - abort has priority over every other input, including a coincident row_done or commit_done.
  - abort in any non-IDLE state: go to IDLE next cycle; clear counters; no done pulse; cfg_err unchanged.
  - start together with abort while in IDLE: start wins.
  - Pulses on ker_load_done, row_done or commit_done in states not waiting for them are ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse.
- Counter widths: out_ch = 256 with CH_W = 9 must not wrap; comparisons are against the latched count minus 1 at full width.
- Total rows streamed per layer = out_ch × in_ch × N.

Test Plan:
- img_log2=2, in_ch=1, out_ch=1, all handshakes answered after 1 cycle → exactly 4 row_start pulses with row_type 0,1,1,2; 1 ker_load_req; 1 oc_commit; done; cfg_err=0.
- img_log2=3, in_ch=3, out_ch=2 → 6 ker_load_req; 48 row_start; acc_clear high only for the 16 rows with cur_ic=0 (8 per output channel); oc_commit after rows 24 and 48; (cur_oc, cur_ic) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
- in_ch=0, or img_log2=1 → no ker_load_req, no row_start; done and cfg_err both high 2 cycles after start; the next legal start clears cfg_err.
- abort asserted in ROW_WAIT on the same cycle as row_done, in_ch=2 → IDLE next cycle, busy=0, counters 0, no done; a new start runs a full layer.
- dp_idle held low for 20 cycles in WAIT_IDLE → no row_start until 1 cycle after dp_idle rises; start pulses issued while busy are ignored.
- reset asserted asynchronously mid-row, img_log2=7, in_ch=256, out_ch=256 → all outputs 0 immediately; a separate full-width run checks that cur_oc reaches 255 without wrap and done pulses exactly once.
